lacc_mem_arbiter: RTL and testbench

LACC_MEM_ARBITER -- requirements
Module: lacc_mem_arbiter

---
 rtl/lacc_mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_lacc_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lacc_mem_arbiter.sv
// Round-robin arbiter funnelling NREQ requesters onto one LACC data port.
// Read responses come back in order and are routed by a tag FIFO.
module lacc_mem_arbiter #(
    parameter int OUTSTANDING = 4,
    parameter int NREQ        = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_addr,
    input  logic [NREQ-1:0]      req_read,
    input  logic [NREQ*32-1:0]   req_wdata,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic                 lacc_data_valid,
    input  logic                 lacc_data_ready,
    output logic [31:0]          lacc_data_addr,
    output logic [31:0]          lacc_data_wdata,
    output logic                 lacc_data_read,
    output logic [1:0]           lacc_data_size,
    input  logic                 lacc_drsp_valid,
    input  logic [31:0]          lacc_drsp_rdata,
    output logic                 busy,
    output logic                 err
);

    localparam int PW = $clog2(OUTSTANDING);
    localparam int TW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef logic [TW-1:0] tag_t;

    tag_t                   tag_q [OUTSTANDING];
    logic [OUTSTANDING-1:0] drop_q;
    logic [PW:0]            wr_ptr;
    logic [PW:0]            rd_ptr;
    logic [PW-1:0]          wr_idx;
    logic [PW-1:0]          rd_idx;
    tag_t                   last_grant;
    tag_t                   lock_idx;
    tag_t                   grant_idx;
    logic                   lock_q;
    logic                   has_grant;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop;
    logic                   push;
    logic                   hs;
    logic                   active;
    int                     k;

    assign wr_idx     = wr_ptr[PW-1:0];
    assign rd_idx     = rd_ptr[PW-1:0];
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_idx == rd_idx) && (wr_ptr[PW] != rd_ptr[PW]);
    assign pop        = lacc_drsp_valid & ~fifo_empty;
    assign active     = rst & ~flush;

    // A pop in this cycle frees a slot, so a read may be granted against a full FIFO.
    always_comb begin
        has_grant = 1'b0;
        grant_idx = last_grant;
        k         = 0;
        if (lock_q) begin
            has_grant = 1'b1;
            grant_idx = lock_idx;
        end else begin
            for (int i = 1; i <= NREQ; i++) begin
                k = (int'(last_grant) + i) % NREQ;
                if (!has_grant && req_valid[k] && (!req_read[k] || !fifo_full || pop)) begin
                    has_grant = 1'b1;
                    grant_idx = tag_t'(k);
                end
            end
        end
    end

    assign lacc_data_valid = has_grant & active;
    assign lacc_data_addr  = lacc_data_valid ? req_addr[int'(grant_idx)*32 +: 32] : 32'd0;
    assign lacc_data_wdata = lacc_data_valid ? req_wdata[int'(grant_idx)*32 +: 32] : 32'd0;
    assign lacc_data_read  = lacc_data_valid & req_read[grant_idx];
    assign lacc_data_size  = 2'b10;
    assign hs              = lacc_data_valid & lacc_data_ready;
    assign push            = hs & lacc_data_read;
    assign busy            = ~fifo_empty;

    always_comb begin
        req_ready = '0;
        if (hs) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        rsp_valid = '0;
        rsp_rdata = 32'd0;
        if (pop && !drop_q[rd_idx] && active) begin
            rsp_valid[tag_q[rd_idx]] = 1'b1;
            rsp_rdata                = lacc_drsp_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            drop_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (PW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (PW+1)'(1);
            end
            // Flush marks every slot; a later push clears its own drop bit.
            if (flush) begin
                drop_q <= '1;
            end else if (push) begin
                drop_q[wr_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tag_q[wr_idx] <= grant_idx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_q     <= 1'b0;
            lock_idx   <= '0;
            last_grant <= tag_t'(NREQ-1);
            err        <= 1'b0;
        end else begin
            if (flush) begin
                lock_q <= 1'b0;
            end else if (lacc_data_valid && !lacc_data_ready) begin
                lock_q   <= 1'b1;
                lock_idx <= grant_idx;
            end else if (hs) begin
                lock_q <= 1'b0;
            end
            if (hs) begin
                last_grant <= grant_idx;
            end
            if (lacc_drsp_valid && fifo_empty) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lacc_mem_arbiter.sv
// Directed bench for lacc_mem_arbiter: arbitration order, lock, FIFO full,
// flush dropping, spurious responses and asynchronous reset.
module tb_lacc_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [95:0] req_addr;
    logic [2:0]  req_read;
    logic [95:0] req_wdata;
    logic [2:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        lacc_data_valid;
    logic        lacc_data_ready;
    logic [31:0] lacc_data_addr;
    logic [31:0] lacc_data_wdata;
    logic        lacc_data_read;
    logic [1:0]  lacc_data_size;
    logic        lacc_drsp_valid;
    logic [31:0] lacc_drsp_rdata;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    lacc_mem_arbiter #(.OUTSTANDING(4), .NREQ(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_addr        (req_addr),
        .req_read        (req_read),
        .req_wdata       (req_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_rdata       (rsp_rdata),
        .lacc_data_valid (lacc_data_valid),
        .lacc_data_ready (lacc_data_ready),
        .lacc_data_addr  (lacc_data_addr),
        .lacc_data_wdata (lacc_data_wdata),
        .lacc_data_read  (lacc_data_read),
        .lacc_data_size  (lacc_data_size),
        .lacc_drsp_valid (lacc_drsp_valid),
        .lacc_drsp_rdata (lacc_drsp_rdata),
        .busy            (busy),
        .err             (err)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic rd, input logic [31:0] a, input logic [31:0] w);
        req_read[i]          = rd;
        req_addr[i*32 +: 32] = a;
        req_wdata[i*32 +: 32] = w;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b0; flush = 1'b0; lacc_data_ready = 1'b0;
        lacc_drsp_valid = 1'b0; lacc_drsp_rdata = 32'd0;
        req_valid = 3'b111; req_read = '0; req_addr = '0; req_wdata = '0;
        set_req(0, 1'b1, 32'h100, 32'h0);
        set_req(1, 1'b1, 32'h200, 32'h0);
        set_req(2, 1'b1, 32'h300, 32'h0);
        #3;
        check_output("rst_valid", lacc_data_valid, 0);
        check_output("rst_ready", req_ready, 0);
        check_output("rst_addr", lacc_data_addr, 0);
        check_output("rst_size", lacc_data_size, 2);
        check_output("rst_busy", busy, 0);
        check_output("rst_err", err, 0);
        repeat (2) tick();
        rst = 1'b1;

        // all three read, ready high: grants 0,1,2,0
        lacc_data_ready = 1'b1;
        #1;
        check_output("rr_g0_addr", lacc_data_addr, 32'h100);
        check_output("rr_g0_ready", req_ready, 3'b001);
        check_output("rr_g0_read", lacc_data_read, 1);
        tick();
        check_output("rr_g1_ready", req_ready, 3'b010);
        check_output("rr_g1_addr", lacc_data_addr, 32'h200);
        check_output("rr_busy", busy, 1);
        tick();
        check_output("rr_g2_ready", req_ready, 3'b100);
        tick();
        check_output("rr_g0b_ready", req_ready, 3'b001);
        tick();
        req_valid = 3'b000;
        lacc_drsp_valid = 1'b1; lacc_drsp_rdata = 32'hD0;
        #1;
        check_output("rr_rsp0", rsp_valid, 3'b001);
        check_output("rr_rdata0", rsp_rdata, 32'hD0);
        tick();
        lacc_drsp_rdata = 32'hD1; #1;
        check_output("rr_rsp1", rsp_valid, 3'b010);
        tick();
        lacc_drsp_rdata = 32'hD2; #1;
        check_output("rr_rsp2", rsp_valid, 3'b100);
        check_output("rr_rdata2", rsp_rdata, 32'hD2);
        tick();
        lacc_drsp_rdata = 32'hD3; #1;
        check_output("rr_rsp3", rsp_valid, 3'b001);
        tick();
        lacc_drsp_valid = 1'b0; #1;
        check_output("rr_idle", busy, 0);

        // requester 1 write stalled by ready=0, requester 0 joins
        lacc_data_ready = 1'b0;
        set_req(1, 1'b0, 32'h1234, 32'hCAFE);
        set_req(0, 1'b1, 32'h400, 32'h0);
        req_valid = 3'b010; #1;
        check_output("lk_valid", lacc_data_valid, 1);
        check_output("lk_addr", lacc_data_addr, 32'h1234);
        check_output("lk_ready", req_ready, 0);
        tick();
        req_valid = 3'b011; #1;
        check_output("lk_addr2", lacc_data_addr, 32'h1234);
        check_output("lk_wdata2", lacc_data_wdata, 32'hCAFE);
        check_output("lk_ready2", req_ready, 0);
        tick();
        check_output("lk_wdata3", lacc_data_wdata, 32'hCAFE);
        check_output("lk_ready3", req_ready, 0);
        tick();
        lacc_data_ready = 1'b1; #1;
        check_output("lk_accept", req_ready, 3'b010);
        tick();
        check_output("lk_next", req_ready, 3'b001);
        check_output("lk_next_addr", lacc_data_addr, 32'h400);
        tick();
        req_valid = 3'b000;
        lacc_drsp_valid = 1'b1; lacc_drsp_rdata = 32'hE0; #1;
        check_output("lk_rsp", rsp_valid, 3'b001);
        tick();
        lacc_drsp_valid = 1'b0;

        // fill four slots, read stalls, write passes, pop unblocks read
        set_req(0, 1'b1, 32'h500, 32'h0);
        set_req(2, 1'b0, 32'h600, 32'h77);
        req_valid = 3'b001;
        repeat (4) tick();
        #1;
        check_output("fl_stall_valid", lacc_data_valid, 0);
        check_output("fl_stall_ready", req_ready, 0);
        check_output("fl_busy", busy, 1);
        tick();
        req_valid = 3'b101; #1;
        check_output("fl_write", req_ready, 3'b100);
        check_output("fl_write_data", lacc_data_wdata, 32'h77);
        tick();
        req_valid = 3'b001; #1;
        check_output("fl_stall2", req_ready, 0);
        lacc_drsp_valid = 1'b1; lacc_drsp_rdata = 32'hF0; #1;
        check_output("fl_unblock", req_ready, 3'b001);
        check_output("fl_pop_rsp", rsp_valid, 3'b001);
        tick();
        req_valid = 3'b000;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_output("fl_drain", rsp_valid, 3'b001);
            tick();
        end
        lacc_drsp_valid = 1'b0; #1;
        check_output("fl_empty", busy, 0);

        // flush with two reads outstanding
        set_req(1, 1'b1, 32'h700, 32'h0);
        set_req(2, 1'b1, 32'h800, 32'h0);
        req_valid = 3'b110; #1;
        check_output("fx_g1", req_ready, 3'b010);
        tick();
        check_output("fx_g2", req_ready, 3'b100);
        tick();
        flush = 1'b1; req_valid = 3'b111; #1;
        check_output("fx_valid", lacc_data_valid, 0);
        check_output("fx_ready", req_ready, 0);
        tick();
        flush = 1'b0; req_valid = 3'b000;
        lacc_drsp_valid = 1'b1; lacc_drsp_rdata = 32'h11; #1;
        check_output("fx_drop1", rsp_valid, 0);
        check_output("fx_busy", busy, 1);
        tick();
        check_output("fx_drop2", rsp_valid, 0);
        tick();
        lacc_drsp_valid = 1'b0; #1;
        check_output("fx_idle", busy, 0);
        check_output("fx_err", err, 0);
        req_valid = 3'b010; #1;
        check_output("fx_new", req_ready, 3'b010);
        tick();
        req_valid = 3'b000;
        lacc_drsp_valid = 1'b1; lacc_drsp_rdata = 32'h22; #1;
        check_output("fx_new_rsp", rsp_valid, 3'b010);
        check_output("fx_new_data", rsp_rdata, 32'h22);
        tick();

        // spurious response
        lacc_drsp_rdata = 32'h33; #1;
        check_output("sp_rsp", rsp_valid, 0);
        tick();
        lacc_drsp_valid = 1'b0; #1;
        check_output("sp_err", err, 1);
        repeat (2) tick();
        check_output("sp_sticky", err, 1);

        // asynchronous reset during a lock
        lacc_data_ready = 1'b0;
        set_req(2, 1'b1, 32'h900, 32'h0);
        req_valid = 3'b100; #1;
        check_output("ar_addr", lacc_data_addr, 32'h900);
        tick();
        req_valid = 3'b101; #1;
        check_output("ar_held", lacc_data_addr, 32'h900);
        #2 rst = 1'b0; #1;
        check_output("ar_valid", lacc_data_valid, 0);
        check_output("ar_err", err, 0);
        check_output("ar_addr0", lacc_data_addr, 0);
        tick();
        rst = 1'b1;
        req_valid = 3'b000;
        lacc_drsp_valid = 1'b1; #1;
        check_output("ar_orphan_rsp", rsp_valid, 0);
        tick();
        lacc_drsp_valid = 1'b0; #1;
        check_output("ar_orphan_err", err, 1);
        lacc_data_ready = 1'b1; req_valid = 3'b111; #1;
        check_output("ar_first", req_ready, 3'b001);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
